// File: rtl/regfile_bus_sequencer.sv
// regfile_bus_sequencer: walks the register-file bus through one ALU operation
// (LATCHSEL, READA, READB, SLAVE, then optional LATCHC/READF) per accepted request.
`default_nettype none

module regfile_bus_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int INDEX_WIDTH = 3,
  parameter int ALU_WAIT    = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic                   i_ReqValid,
  output logic                   o_ReqReady,
  input  logic [INDEX_WIDTH-1:0] i_SelA,
  input  logic [INDEX_WIDTH-1:0] i_SelB,
  input  logic [INDEX_WIDTH-1:0] i_SelC,
  input  logic [1:0]             i_WSel,
  output logic [3:0]             o_Command,
  output logic [DATA_WIDTH-1:0]  o_BusData,
  input  logic [DATA_WIDTH-1:0]  i_BusData,
  output logic [1:0]             o_AluWSel,
  output logic [DATA_WIDTH-1:0]  o_Flags,
  output logic                   o_Done,
  output logic                   o_Err
);

  localparam logic [3:0] c_COM_NOP      = 4'd0;
  localparam logic [3:0] c_COM_READA    = 4'd1;
  localparam logic [3:0] c_COM_READB    = 4'd2;
  localparam logic [3:0] c_COM_LATCHC   = 4'd3;
  localparam logic [3:0] c_COM_LATCHSEL = 4'd4;
  localparam logic [3:0] c_COM_READF    = 4'd5;
  localparam logic [3:0] c_COM_SLAVE    = 4'd6;

  localparam logic [1:0] c_WSEL_NONE = 2'd0;
  localparam logic [1:0] c_WSEL_REGC = 2'd1;
  localparam logic [1:0] c_WSEL_REGF = 2'd2;
  localparam logic [1:0] c_WSEL_RFU  = 2'd3;

  localparam logic [INDEX_WIDTH-1:0] c_R_ZERO = '0;
  localparam logic [3:0] c_WAIT_LOAD = 4'(ALU_WAIT - 1);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_LATCHSEL = 3'd1;
  localparam logic [2:0] c_ST_READA    = 3'd2;
  localparam logic [2:0] c_ST_READB    = 3'd3;
  localparam logic [2:0] c_ST_EXEC     = 3'd4;
  localparam logic [2:0] c_ST_LATCHC   = 3'd5;
  localparam logic [2:0] c_ST_READF    = 3'd6;
  localparam logic [2:0] c_ST_DONE     = 3'd7;

  logic [2:0]             r_State, w_NextState;
  logic [3:0]             r_Cnt, w_NextCnt;
  logic [INDEX_WIDTH-1:0] r_SelC;
  logic [1:0]             r_WSel;
  logic                   r_ReqReady, r_Done, r_Err;
  logic [3:0]             r_Command;
  logic [DATA_WIDTH-1:0]  r_BusData, r_Flags;
  logic [1:0]             r_AluWSel;

  logic                   w_Accept;
  logic                   w_ReqReady, w_Done, w_Err;
  logic [3:0]             w_Command;
  logic [DATA_WIDTH-1:0]  w_BusData;
  logic [1:0]             w_AluWSel;

  assign w_Accept = i_ReqValid && r_ReqReady;

  // Outputs are computed from the next state so they register in step with it.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      r_State    <= c_ST_IDLE;
      r_Cnt      <= '0;
      r_SelC     <= '0;
      r_WSel     <= c_WSEL_NONE;
      r_ReqReady <= 1'b1;
      r_Command  <= c_COM_NOP;
      r_BusData  <= '0;
      r_AluWSel  <= c_WSEL_NONE;
      r_Flags    <= '0;
      r_Done     <= 1'b0;
      r_Err      <= 1'b0;
    end else begin
      r_State    <= w_NextState;
      r_Cnt      <= w_NextCnt;
      r_ReqReady <= w_ReqReady;
      r_Command  <= w_Command;
      r_BusData  <= w_BusData;
      r_AluWSel  <= w_AluWSel;
      r_Done     <= w_Done;
      r_Err      <= w_Err;
      if (w_Accept) begin
        r_SelC <= i_SelC;
        r_WSel <= i_WSel;
      end
      if (r_State == c_ST_READF) begin
        r_Flags <= i_BusData;
      end
    end
  end

  always_comb begin
    w_NextState = r_State;
    w_NextCnt   = r_Cnt;
    case (r_State)
      c_ST_IDLE:     if (w_Accept) w_NextState = c_ST_LATCHSEL;
      c_ST_LATCHSEL: w_NextState = c_ST_READA;
      c_ST_READA:    w_NextState = c_ST_READB;
      c_ST_READB: begin
        w_NextState = c_ST_EXEC;
        w_NextCnt   = c_WAIT_LOAD;
      end
      c_ST_EXEC: begin
        if (r_Cnt != 4'd0) begin
          w_NextCnt = r_Cnt - 4'd1;
        end else if (r_WSel == c_WSEL_REGC && r_SelC != c_R_ZERO) begin
          w_NextState = c_ST_LATCHC;
        end else if (r_WSel == c_WSEL_REGF) begin
          w_NextState = c_ST_READF;
        end else begin
          w_NextState = c_ST_DONE;
        end
      end
      c_ST_LATCHC:   w_NextState = c_ST_DONE;
      c_ST_READF:    w_NextState = c_ST_DONE;
      c_ST_DONE:     w_NextState = c_ST_IDLE;
      default:       w_NextState = c_ST_IDLE;
    endcase
  end

  // LATCHSEL is only reachable from an accept, so the select packing comes straight from the inputs.
  always_comb begin
    w_ReqReady = 1'b0;
    w_Command  = c_COM_NOP;
    w_BusData  = '0;
    w_AluWSel  = c_WSEL_NONE;
    w_Done     = 1'b0;
    w_Err      = 1'b0;
    case (w_NextState)
      c_ST_IDLE:     w_ReqReady = 1'b1;
      c_ST_LATCHSEL: begin
        w_Command = c_COM_LATCHSEL;
        w_BusData = DATA_WIDTH'({i_SelC, i_SelB, i_SelA});
      end
      c_ST_READA:    w_Command = c_COM_READA;
      c_ST_READB:    w_Command = c_COM_READB;
      c_ST_EXEC: begin
        w_Command = c_COM_SLAVE;
        w_AluWSel = r_WSel;
      end
      c_ST_LATCHC:   w_Command = c_COM_LATCHC;
      c_ST_READF:    w_Command = c_COM_READF;
      c_ST_DONE: begin
        w_Done = 1'b1;
        w_Err  = (r_WSel == c_WSEL_RFU);
      end
      default:       w_ReqReady = 1'b0;
    endcase
  end

  assign o_ReqReady = r_ReqReady;
  assign o_Command  = r_Command;
  assign o_BusData  = r_BusData;
  assign o_AluWSel  = r_AluWSel;
  assign o_Flags    = r_Flags;
  assign o_Done     = r_Done;
  assign o_Err      = r_Err;

endmodule

`default_nettype wire

// File: doc/regfile_bus_sequencer.md
Name: regfile_bus_sequencer

Overview:
Upstream command sequencer for the register file. Accepts one register-to-register ALU operation via a valid/ready handshake and walks the register-file bus through the command sequence. Issued commands are LATCHSEL, READA, READB, SLAVE, then LATCHC or READF, using the regfile_pkg command_t and write_sel_t encodings. It reports completion with a one-cycle done pulse.

Parameters:
DATA_WIDTH, 16, width of shared register-file data bus
INDEX_WIDTH, 3, register index width (matches regfile_pkg::INDEX_WIDTH)
ALU_WAIT, 1, cycles the SLAVE command is held for ALU result; legal range 1..15

Ports:
i_Clk  in  1  system clock
i_Reset_n  in  1  synchronous active-low reset
i_ReqValid  in  1  operation request valid
o_ReqReady  out  1  sequencer idle, can accept request
i_SelA  in  INDEX_WIDTH  source register A index
i_SelB  in  INDEX_WIDTH  source register B index
i_SelC  in  INDEX_WIDTH  destination register index
i_WSel  in  2  write_sel_t for this operation
o_Command  out  4  command_t driven onto regfile bus
o_BusData  out  DATA_WIDTH  data driven on bus (select packing during LATCHSEL, else 0)
i_BusData  in  DATA_WIDTH  data returned by bus (sampled in READF)
o_AluWSel  out  2  write_sel_t to ALU, valid only while o_Command==COM_SLAVE, else WSEL_NONE
o_Flags  out  DATA_WIDTH  flags captured by last READF
o_Done  out  1  one-cycle pulse at operation end
o_Err  out  1  set with o_Done when i_WSel==WSEL_RFU

Behaviour:
- Clock is i_Clk; reset is synchronous, active-low (i_Reset_n sampled on rising edge). All outputs registered.
- Reset values: state IDLE, o_ReqReady=1, o_Command=COM_NOP, o_BusData=0, o_AluWSel=WSEL_NONE, o_Flags=0, o_Done=0, o_Err=0.
- States: IDLE, LATCHSEL, READA, READB, EXEC, LATCHC, READF, DONE.
- IDLE: o_ReqReady=1. Accept when i_ReqValid&&o_ReqReady. Capture SelA/B/C and WSel, then go to LATCHSEL. No acceptance in any other state (o_ReqReady=0).
- LATCHSEL (1 cycle): o_Command=COM_LATCHSEL; o_BusData={zeros, SelC, SelB, SelA}, with SelA at bits [INDEX_WIDTH-1:0].
- READA (1 cycle): COM_READA. READB (1 cycle): COM_READB.
- EXEC: COM_SLAVE held exactly ALU_WAIT cycles; o_AluWSel=captured WSel. Down-counter loads ALU_WAIT-1 on entry.
- After EXEC, by captured WSel:
  - WSEL_REGC with SelC!=R_ZERO: go to LATCHC (1 cycle, COM_LATCHC).
  - WSEL_REGC with SelC==R_ZERO: skip LATCHC; go to DONE.
  - WSEL_REGF: go to READF (1 cycle, COM_READF). o_Flags<=i_BusData at the end of that cycle.
  - WSEL_NONE: go to DONE.
  - WSEL_RFU: go to DONE with o_Err=1.
- DONE (1 cycle): o_Command=COM_NOP, o_Done=1; o_Err valid this cycle only. Next state is IDLE.
  - o_ReqReady returns high the cycle after DONE; there are no back-to-back overlapped operations.
- o_Command=COM_NOP and o_BusData=0 in IDLE and DONE.
- Latency (ALU_WAIT=1, REGC): accept at cycle 0. Commands on cycles 1..5 are 4,1,2,6,3. o_Done at cycle 6; o_ReqReady at cycle 7.
- o_Flags holds its value until the next READF or reset.
- Reset asserted in any state: next cycle is IDLE with all reset values. No partial command is emitted after reset and no o_Done is produced.
- i_ReqValid while busy is ignored; the requester must hold it until ready.

Test Plan:
- Reset then i_ReqValid=1, SelA=1, SelB=2, SelC=3, WSel=REGC, ALU_WAIT=1 -> o_Command sequence 4,1,2,6,3,0. o_BusData=0x00D1 during LATCHSEL. o_AluWSel=01 only on the SLAVE cycle. o_Done at cycle 6.
- WSel=REGF, i_BusData=0x0005 during READF -> o_Command 4,1,2,6,5. o_Flags=0x0005 after READF. o_Done asserted, o_Err=0.
- WSel=REGC, SelC=0 -> no COM_LATCHC issued. o_Done one cycle after SLAVE.
- ALU_WAIT=3, WSel=NONE -> COM_SLAVE for exactly 3 consecutive cycles, then DONE. o_Err=0.
- WSel=RFU -> o_Done and o_Err both 1 for a single cycle. o_Flags unchanged.
- i_Reset_n low during EXEC -> next cycle o_Command=NOP, o_ReqReady=1, o_Done never pulses. A new request then completes normally.
